mux_n_rr: RTL

//   Parametrised N-input, W-bit registered stream multiplexer with valid/ready handshakes.

---
 rtl/mux_n_rr.sv | 90 +++++++++
 1 files changed

// File: rtl/mux_n_rr.sv
// N-input registered stream multiplexer: fixed-select or round-robin channel choice,
// one output beat held in a register until the consumer accepts it.
module mux_n_rr #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    // Handshake: a beat moves on any clock edge where valid && ready are both high;
    // a producer keeps data stable while valid && !ready, and valid never waits on ready.
    logic [SELW-1:0] r_ptr;
    logic [W-1:0]    r_data;
    logic [SELW-1:0] r_ch;
    logic            r_valid;

    logic [SELW-1:0] w_gnt;
    logic            w_gv;
    logic            w_load;
    int              w_idx;

    assign w_load = !r_valid || out_ready;

    // Round-robin scans from the far end back so the channel closest to r_ptr wins last.
    always_comb begin
        w_gnt = '0;
        w_gv  = 1'b0;
        w_idx = 0;
        if (!mode) begin
            w_gnt = sel;
            w_gv  = (int'(sel) < N) && in_valid[sel];
        end else begin
            w_gv = |in_valid;
            for (int k = N - 1; k >= 0; k--) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N) begin
                    w_idx = w_idx - N;
                end
                if (in_valid[w_idx]) begin
                    w_gnt = SELW'(w_idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_load && w_gv) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_gv) begin
                r_valid <= 1'b1;
                r_data  <= in_data[int'(w_gnt)*W +: W];
                r_ch    <= w_gnt;
                if (int'(w_gnt) == N - 1) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt + 1'b1;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule
